hazard_sched: RTL and testbench

- Pipeline sequencing controller for the five-stage RISC-V core. Sits beside the main decoder and drives the stall/flush enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard types:
  - load-use data hazards;
  - taken branch / JAL / JALR control hazards;
  - variable-latency data-memory accesses, through a req/ack handshake with a timeout.
- Keeps a free-running stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_sched_if.sv | 49 ++++
 rtl/hazard_sched_load_use_detect.sv | 32 +++
 rtl/hazard_sched.sv | 182 ++++++++++++++++++
 tb/tb_hazard_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
//   sched_state_t : scheduler FSM state (RUN, WAIT, ERR)
//   REG_ADDR_W    : architectural register index width
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/hazard_sched_if.sv
// Bundle of pipeline-control signals exchanged between the core datapath and
// the hazard scheduler.
//   ID/EX/MEM status : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
//                      ex_memread, ex_redirect, mem_access
//   Data memory      : dmem_req (scheduler -> memory), dmem_ack (memory -> scheduler)
//   Pipeline control : pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
//                      if_id_flush, id_ex_flush, mem_wb_bubble
//   Status           : mem_err pulse, stall_cnt performance counter
// The scheduler uses the slave modport; the pipeline side uses master.
interface hazard_sched_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_memread;
  logic                  ex_redirect;
  logic                  mem_access;
  logic                  dmem_ack;
  logic                  dmem_req;
  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  id_ex_stall;
  logic                  ex_mem_stall;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  mem_wb_bubble;
  logic                  mem_err;
  logic [CNT_W-1:0]      stall_cnt;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
    input  ex_redirect, mem_access, dmem_ack,
    output dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, stall_cnt
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
    output ex_redirect, mem_access, dmem_ack,
    input  dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input  if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, stall_cnt
  );

endinterface

// File: rtl/hazard_sched_load_use_detect.sv
// Combinational load-use hazard detector.
//   Inputs : id_rs1, id_rs2, id_use_rs1, id_use_rs2 (ID instruction sources)
//            ex_rd, ex_memread (load currently in EX)
//   Output : load_use - ID reads a register the EX load has not produced yet.
// x0 is never a hazard because it is hardwired to zero.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  output logic                  load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // Source-register match against the load destination
  always_comb begin
    rs1_hit_s = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit_s = id_use_rs2 && (id_rs2 == ex_rd);
    if (ex_memread && (ex_rd != {REG_ADDR_W{1'b0}})) begin
      load_use = rs1_hit_s || rs2_hit_s;
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller for the five-stage core.
//   clk, rst_n : core clock, asynchronous active-low reset
//   hs         : hazard_sched_if.slave - pipeline status in, stall/flush/bubble
//                enables, data-memory req/ack, mem_err and stall_cnt out.
// Memory stalls freeze the whole front of the pipeline and defer redirects and
// load-use handling; a stalled access is abandoned after TIMEOUT_CYCLES cycles
// (one ERR cycle, which lets the failing instruction advance).
// Control outputs are combinational from state and inputs and forced low while
// rst_n is asserted.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
)(
  input  logic           clk,
  input  logic           rst_n,
  hazard_sched_if.slave  hs
);

  localparam int                WAIT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t      state_r;
  sched_state_t      state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic load_use_s;
  logic mem_stall_s;
  logic req_s;
  logic dmem_req_s;
  logic pc_stall_s;
  logic if_id_stall_s;
  logic id_ex_stall_s;
  logic ex_mem_stall_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic mem_wb_bubble_s;
  logic mem_err_s;

  load_use_detect u_load_use_detect (
    .id_rs1     (hs.id_rs1),
    .id_rs2     (hs.id_rs2),
    .id_use_rs1 (hs.id_use_rs1),
    .id_use_rs2 (hs.id_use_rs2),
    .ex_rd      (hs.ex_rd),
    .ex_memread (hs.ex_memread),
    .load_use   (load_use_s)
  );

  // Memory-access decode: request and stall condition for the current state
  always_comb begin
    mem_stall_s = 1'b0;
    req_s       = 1'b0;
    case (state_r)
      RUN: begin
        req_s       = hs.mem_access;
        mem_stall_s = hs.mem_access && !hs.dmem_ack;
      end
      WAIT: begin
        req_s       = 1'b1;
        mem_stall_s = !hs.dmem_ack;
      end
      ERR: begin
        // Failed access is dropped so the instruction can retire.
        req_s       = 1'b0;
        mem_stall_s = 1'b0;
      end
      default: begin
        req_s       = 1'b0;
        mem_stall_s = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (mem_stall_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      WAIT: begin
        if (hs.dmem_ack) begin
          state_nxt_s = RUN;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ERR:     state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // Wait counter: the RUN cycle that first stalls counts as cycle 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if ((state_r == RUN) && mem_stall_s) begin
      wait_cnt_r <= WAIT_W'(1);
    end else if ((state_r == WAIT) && !hs.dmem_ack && (wait_cnt_r != WAIT_LAST)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // FSM outputs: memory stall outranks redirect, redirect outranks load-use
  always_comb begin
    dmem_req_s      = 1'b0;
    pc_stall_s      = 1'b0;
    if_id_stall_s   = 1'b0;
    id_ex_stall_s   = 1'b0;
    ex_mem_stall_s  = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    mem_wb_bubble_s = 1'b0;
    mem_err_s       = 1'b0;
    if (!rst_n) begin
      dmem_req_s = 1'b0;
    end else begin
      dmem_req_s = req_s;
      mem_err_s  = (state_r == ERR);
      if (mem_stall_s) begin
        pc_stall_s      = 1'b1;
        if_id_stall_s   = 1'b1;
        id_ex_stall_s   = 1'b1;
        ex_mem_stall_s  = 1'b1;
        mem_wb_bubble_s = 1'b1;
      end else if (hs.ex_redirect) begin
        // ID holds a wrong-path instruction, so its hazard is irrelevant.
        if_id_flush_s = 1'b1;
        id_ex_flush_s = 1'b1;
      end else if (load_use_s) begin
        pc_stall_s    = 1'b1;
        if_id_stall_s = 1'b1;
        id_ex_flush_s = 1'b1;
      end else begin
        pc_stall_s = 1'b0;
      end
    end
  end

  // Stall performance counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (pc_stall_s) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hs.dmem_req      = dmem_req_s;
  assign hs.pc_stall      = pc_stall_s;
  assign hs.if_id_stall   = if_id_stall_s;
  assign hs.id_ex_stall   = id_ex_stall_s;
  assign hs.ex_mem_stall  = ex_mem_stall_s;
  assign hs.if_id_flush   = if_id_flush_s;
  assign hs.id_ex_flush   = id_ex_flush_s;
  assign hs.mem_wb_bubble = mem_wb_bubble_s;
  assign hs.mem_err       = mem_err_s;
  assign hs.stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: the driver applies stimulus shortly after
// each rising edge and pushes the model's expected outputs; a monitor pops and
// compares on every falling edge.
module tb_hazard_sched;

  localparam int T  = 8;
  localparam int CW = 32;

  typedef struct packed {
    logic [8:0]    ctl;   // req, pc, if_id, id_ex, ex_mem stalls, if_id/id_ex flush, bubble, err
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_sched_if #(.CNT_W(CW)) bus ();

  hazard_sched #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (bus.slave)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: consecutive stalled cycles of the outstanding access,
  // a pending abandon cycle, and the stall counter.
  int            m_stalled = 0;
  bit            m_err     = 1'b0;
  logic [CW-1:0] m_cnt     = '0;

  task automatic predict();
    exp_t e;
    bit req, ms, merr, lu, fl, lus, stall;
    if (!rst_n) begin
      m_stalled = 0;
      m_err     = 1'b0;
      m_cnt     = '0;
      e.ctl     = '0;
      e.cnt     = '0;
      q.push_back(e);
      return;
    end
    merr = m_err;
    if (m_err) begin
      req = 1'b0; ms = 1'b0;
    end else if (m_stalled > 0) begin
      req = 1'b1; ms = !bus.dmem_ack;
    end else begin
      req = bus.mem_access; ms = bus.mem_access && !bus.dmem_ack;
    end
    lu = bus.ex_memread && (bus.ex_rd != 0) &&
         ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    fl    = !ms && bus.ex_redirect;
    lus   = !ms && !bus.ex_redirect && lu;
    stall = ms || lus;
    e.ctl = {req, stall, stall, ms, ms, fl, fl | lus, ms, merr};
    e.cnt = m_cnt;
    q.push_back(e);
    if (stall) m_cnt = m_cnt + 1;
    if (m_err) begin
      m_err = 1'b0; m_stalled = 0;
    end else if (ms) begin
      m_stalled++;
      if (m_stalled == T) begin
        m_err = 1'b1; m_stalled = 0;
      end
    end else begin
      m_stalled = 0;
    end
  endtask

  task automatic drive(input bit rst, input bit ma, input bit ack, input bit mrd,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit redir);
    @(posedge clk);
    #1;
    cyc++;
    rst_n          = rst;
    bus.mem_access = ma;
    bus.dmem_ack   = ack;
    bus.ex_memread = mrd;
    bus.ex_rd      = rd;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.ex_redirect = redir;
    predict();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.dmem_req, bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
             bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble, bus.mem_err};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl cycle %0d: got %b expected %b", cyc, act, e.ctl);
      end
      checks++;
      if (bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL stall_cnt cycle %0d: got %0d expected %0d", cyc, bus.stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    bus.mem_access = 1'b0; bus.dmem_ack = 1'b0; bus.ex_memread = 1'b0; bus.ex_rd = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_redirect = 1'b0;

    // Reset state, with hazard-looking inputs that must be masked
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Load-use, one bubble; then ex_rd = x0 gives nothing
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Redirect beats load-use
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
    idle(1);

    // Zero-wait access
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Memory wait, ack on cycle 3
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Timeout: stall 0..T-1, err on T, back to RUN on T+1
    for (int i = 0; i < T + 1; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset mid-wait (applied between clock edges)
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Deferred redirect during a memory stall
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Randomized traffic with small register space and occasional resets
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) < 2),
            $urandom_range(0, 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
